// File: rtl/core_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// core_sequencer: feeds one n-gram of symbols to NUM_CORES parallel cores and
// streams back their accumulators.  Rev 1.0
// ----------------------------------------------------------------------------
module core_sequencer #(
  parameter int NUM_CORES = 8,
  parameter int NGRAM     = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  input  logic [8:0]              sym_data,
  input  logic                    sym_last,
  output logic                    core_init,
  output logic                    core_exec,
  output logic [31:0]             core_src_data,
  output logic                    core_out_period,
  output logic                    core_update,
  input  logic [32*NUM_CORES-1:0] core_acc,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [31:0]             res_data,
  output logic                    res_last,
  output logic                    busy,
  output logic [15:0]             gram_cnt
);

  localparam int            IW         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [IW-1:0] c_LAST_IDX = IW'(NUM_CORES - 1);
  localparam logic [3:0]    c_NGRAM    = 4'(NGRAM);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_EXEC  = 3'd2,
    S_DRAIN = 3'd3,
    S_LATCH = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_sym_cnt;
  logic [1:0]    r_drain_cnt;
  logic [IW-1:0] r_idx;
  logic [15:0]   r_gram_cnt;
  logic [31:0]   w_acc [NUM_CORES];
  logic          w_sym_fire;
  logic          w_gram_end;
  logic          w_last_word;
  logic          w_res_fire;
  logic          w_drain_done;

  generate
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_slice
      assign w_acc[g] = core_acc[32*g +: 32];
    end
  endgenerate

  assign w_sym_fire   = (r_state == S_EXEC) && sym_valid;
  assign w_gram_end   = w_sym_fire && (((r_sym_cnt + 4'd1) == c_NGRAM) || sym_last);
  assign w_last_word  = (r_idx == c_LAST_IDX);
  assign w_res_fire   = (r_state == S_OUT) && res_ready;
  // Three drain cycles cover memory read, m2 register and accumulate.
  assign w_drain_done = (r_drain_cnt == 2'd2);

  assign core_update = 1'b0;
  assign gram_cnt    = r_gram_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    sym_ready       = 1'b0;
    core_init       = 1'b0;
    core_exec       = 1'b0;
    core_src_data   = 32'd0;
    core_out_period = 1'b0;
    res_valid       = 1'b0;
    res_data        = 32'd0;
    res_last        = 1'b0;
    busy            = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (en && sym_valid) w_next = S_INIT;
      end
      S_INIT: begin
        core_init = 1'b1;
        w_next    = S_EXEC;
      end
      S_EXEC: begin
        sym_ready     = 1'b1;
        core_exec     = sym_valid;
        core_src_data = {23'd0, sym_data};
        if (w_gram_end) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drain_done) w_next = S_LATCH;
      end
      S_LATCH: begin
        core_out_period = 1'b1;
        w_next          = S_OUT;
      end
      S_OUT: begin
        res_valid = 1'b1;
        res_data  = w_acc[r_idx];
        res_last  = w_last_word;
        if (res_ready && w_last_word) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sym_cnt   <= 4'd0;
      r_drain_cnt <= 2'd0;
      r_idx       <= '0;
      r_gram_cnt  <= 16'd0;
    end else begin
      if ((r_state == S_IDLE) && (w_next == S_INIT)) r_sym_cnt <= 4'd0;
      else if (w_sym_fire)                          r_sym_cnt <= r_sym_cnt + 4'd1;

      if (r_state == S_DRAIN) r_drain_cnt <= w_drain_done ? 2'd0 : r_drain_cnt + 2'd1;
      else                    r_drain_cnt <= 2'd0;

      if (w_res_fire) begin
        if (w_last_word) begin
          r_idx      <= '0;
          r_gram_cnt <= r_gram_cnt + 16'd1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// Directed bench for core_sequencer with symbol and result scoreboards.
module tb_core_sequencer;
  localparam int NC = 8;
  localparam int NG = 3;

  logic          clk = 1'b0;
  logic          rst_n, en, sym_valid, sym_ready, sym_last;
  logic [8:0]    sym_data;
  logic          core_init, core_exec, core_out_period, core_update;
  logic [31:0]   core_src_data;
  logic [32*NC-1:0] core_acc;
  logic          res_valid, res_ready, res_last, busy;
  logic [31:0]   res_data;
  logic [15:0]   gram_cnt;

  core_sequencer #(.NUM_CORES(NC), .NGRAM(NG)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_data(sym_data), .sym_last(sym_last), .core_init(core_init), .core_exec(core_exec),
    .core_src_data(core_src_data), .core_out_period(core_out_period), .core_update(core_update),
    .core_acc(core_acc), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .busy(busy), .gram_cnt(gram_cnt)
  );

  always #5 clk = ~clk;

  logic [32:0] exp_res [$];
  logic [31:0] exp_src [$];
  int n_vec = 0, n_err = 0, cyc = 0;
  int n_init = 0, n_exec = 0, n_op = 0, n_res = 0, n_stall = 0;
  int init_cyc = 0, first_exec_cyc = 0, last_exec_cyc = 0, op_cyc = 0, first_rv_cyc = 0;
  bit want_first_exec = 0, want_first_rv = 0, stall_prev = 0;
  logic [31:0] stall_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: samples on the falling edge, scores exec symbols and result words.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      chk("init_exec_overlap", {63'd0, core_init & core_exec}, 64'd0);
      chk("core_update_zero", {63'd0, core_update}, 64'd0);
      if (core_init) begin
        n_init++; init_cyc = cyc; want_first_exec = 1;
      end
      if (core_exec) begin
        n_exec++; last_exec_cyc = cyc;
        if (want_first_exec) begin first_exec_cyc = cyc; want_first_exec = 0; end
        chk("src_expected", {63'd0, exp_src.size() != 0}, 64'd1);
        if (exp_src.size() != 0) chk("src_data", core_src_data, exp_src.pop_front());
      end
      if (core_out_period) begin
        n_op++; op_cyc = cyc; want_first_rv = 1;
      end
      if (res_valid && want_first_rv) begin first_rv_cyc = cyc; want_first_rv = 0; end
      if (stall_prev && res_valid) begin
        n_stall++;
        chk("stall_stable", res_data, stall_data);
      end
      if (res_valid && res_ready) begin
        n_res++;
        chk("res_expected", {63'd0, exp_res.size() != 0}, 64'd1);
        if (exp_res.size() != 0) chk("res_word", {res_last, res_data}, exp_res.pop_front());
      end
      stall_prev = res_valid && !res_ready;
      stall_data = res_data;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_acc(input logic [31:0] base, input logic [31:0] step);
    for (int k = 0; k < NC; k++) begin
      core_acc[32*k +: 32] = base + 32'(k) * step;
      exp_res.push_back({(k == NC-1), base + 32'(k) * step});
    end
  endtask

  task automatic drive_sym(input logic [8:0] d, input logic last);
    bit acc = 0;
    sym_valid = 1; sym_data = d; sym_last = last;
    exp_src.push_back({23'd0, d});
    for (int i = 0; i < 50 && !acc; i++) begin
      if (sym_ready) acc = 1;
      tick();
    end
    chk("sym_accept", {63'd0, acc}, 64'd1);
    sym_valid = 0; sym_last = 0;
  endtask

  task automatic bubble();
    sym_valid = 0; tick();
  endtask

  task automatic wait_gram(input logic [15:0] target, input bit toggle);
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      res_ready = toggle ? ((i % 3) == 0) : 1'b1;
      tick();
      if (gram_cnt == target) done = 1;
    end
    res_ready = 1;
    chk("gram_done", {63'd0, done}, 64'd1);
  endtask

  int s_init, s_exec, s_op, s_res, s_stall;
  task automatic snap();
    s_init = n_init; s_exec = n_exec; s_op = n_op; s_res = n_res; s_stall = n_stall;
  endtask

  initial begin
    rst_n = 0; en = 1; sym_valid = 1; sym_data = 9'h1FF; sym_last = 0;
    core_acc = '0; res_ready = 1;
    repeat (3) tick();
    chk("rst_ctrl", {56'd0, sym_ready, busy, core_init, core_exec, core_out_period,
                     core_update, res_valid, res_last}, 64'd0);
    chk("rst_gram_cnt", gram_cnt, 64'd0);
    chk("rst_src_data", core_src_data, 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    sym_valid = 0; sym_data = 0;
    rst_n = 1; tick();

    // Abort a gram with reset during DRAIN.
    drive_sym(9'h11, 0); drive_sym(9'h12, 0); drive_sym(9'h13, 0);
    tick();
    rst_n = 0; #1;
    chk("abort_busy_in_rst", {63'd0, busy}, 64'd0);
    tick(); tick();
    rst_n = 1;
    repeat (10) tick();
    chk("abort_no_out_period", n_op, 64'd0);
    chk("abort_no_result", n_res, 64'd0);
    chk("abort_gram_cnt", gram_cnt, 64'd0);
    chk("abort_idle", {63'd0, busy}, 64'd0);

    // Back-to-back 5,6,7.
    snap();
    load_acc(32'h1000_0000, 32'h0000_0101);
    drive_sym(9'd5, 0); drive_sym(9'd6, 0); drive_sym(9'd7, 0);
    wait_gram(16'd1, 0);
    chk("g1_init_pulses", n_init - s_init, 64'd1);
    chk("g1_exec_beats", n_exec - s_exec, 64'd3);
    chk("g1_out_period", n_op - s_op, 64'd1);
    chk("g1_words", n_res - s_res, 64'd8);
    chk("g1_init_to_exec", first_exec_cyc - init_cyc, 64'd1);
    chk("g1_drain_len", op_cyc - last_exec_cyc, 64'd4);
    chk("g1_latch_to_valid", first_rv_cyc - op_cyc, 64'd1);
    chk("g1_gram_cnt", gram_cnt, 64'd1);
    chk("g1_busy_after", {63'd0, busy}, 64'd0);

    // Single symbol 0 closed early by sym_last.
    snap();
    load_acc(32'd33215360, 32'd0);
    drive_sym(9'd0, 1);
    wait_gram(16'd2, 0);
    chk("g2_exec_beats", n_exec - s_exec, 64'd1);
    chk("g2_drain_len", op_cyc - last_exec_cyc, 64'd4);
    chk("g2_words", n_res - s_res, 64'd8);

    // Bubbles inside EXEC.
    snap();
    load_acc(32'hA5A5_0000, 32'h0000_0011);
    drive_sym(9'd1, 0); bubble(); bubble(); drive_sym(9'd2, 0); drive_sym(9'd3, 0);
    wait_gram(16'd3, 0);
    chk("g3_exec_beats", n_exec - s_exec, 64'd3);
    chk("g3_drain_after_last", op_cyc - last_exec_cyc, 64'd4);
    chk("g3_words", n_res - s_res, 64'd8);

    // Consumer back-pressure 1,0,0,...
    snap();
    load_acc(32'hDEAD_0000, 32'h0001_0003);
    drive_sym(9'd20, 0); drive_sym(9'd21, 0); drive_sym(9'd22, 0);
    wait_gram(16'd4, 1);
    chk("g4_words", n_res - s_res, 64'd8);
    chk("g4_stalls_seen", {63'd0, (n_stall - s_stall) > 0}, 64'd1);

    // en low holds IDLE with a symbol waiting.
    snap();
    en = 0; sym_valid = 1; sym_data = 9'd9;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("en0_sym_ready", {63'd0, sym_ready}, 64'd0);
      chk("en0_busy", {63'd0, busy}, 64'd0);
    end
    chk("en0_no_init", n_init - s_init, 64'd0);
    load_acc(32'h0BAD_F00D, 32'h0000_0100);
    en = 1; tick();
    chk("en1_init_next", {63'd0, core_init}, 64'd1);
    drive_sym(9'd9, 0); drive_sym(9'd10, 0); drive_sym(9'd11, 0);
    wait_gram(16'd5, 0);
    chk("g5_gram_cnt", gram_cnt, 64'd5);
    chk("g5_words", n_res - s_res, 64'd8);

    repeat (3) tick();
    chk("src_queue_empty", exp_src.size(), 64'd0);
    chk("res_queue_empty", exp_res.size(), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter NUM_CORES, default 8, the number of core instances driven in parallel and read back.
REQ-002 SHALL have parameter NGRAM, default 3, the symbols per gram; legal range is 1..8 because the core permutation counter is 3 bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  when high, allows a new gram to start from IDLE.
REQ-006 SHALL have port sym_valid  input  1  an input symbol is offered.
REQ-007 SHALL have port sym_ready  output  1  the input symbol is accepted in this cycle.
REQ-008 SHALL have port sym_data  input  9  the item-memory index.
REQ-009 SHALL have port sym_last  input  1  the current symbol closes the gram early.
REQ-010 SHALL have port core_init  output  1  broadcast to the init input of every core.
REQ-011 SHALL have port core_exec  output  1  broadcast to the exec input of every core.
REQ-012 SHALL have port core_src_data  output  32  broadcast symbol value, equal to {23'b0, sym_data}.
REQ-013 SHALL have port core_out_period  output  1  broadcast; latches the core accumulators into their output registers.
REQ-014 SHALL have port core_update  output  1  broadcast; always driven 0 (bypass of the core output register is unused).
REQ-015 SHALL have port core_acc  input  32*NUM_CORES  the acc outputs of the cores; core k occupies bits [32k+31:32k].
REQ-016 SHALL have port res_valid  output  1  a result word is offered.
REQ-017 SHALL have port res_ready  input  1  the consumer accepts the result word.
REQ-018 SHALL have port res_data  output  32  the result word.
REQ-019 SHALL have port res_last  output  1  marks the word from core NUM_CORES-1.
REQ-020 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-021 SHALL have port gram_cnt  output  16  count of completed grams.

Function
REQ-022 SHALL implement FSM states IDLE, INIT, EXEC, DRAIN, LATCH, OUT.
REQ-023 IDLE: when en=1 and sym_valid=1, SHALL go to INIT without consuming the symbol; otherwise SHALL stay in IDLE.
REQ-024 INIT: SHALL assert core_init for exactly 1 cycle and SHALL go to EXEC on the next cycle.
REQ-025 EXEC: sym_ready SHALL be 1; core_exec SHALL equal sym_valid, and core_src_data SHALL be valid in the same cycle.
REQ-026 EXEC: a bubble (sym_valid=0) SHALL leave core_exec=0 and SHALL NOT advance the symbol counter.
REQ-027 EXEC SHALL exit to DRAIN on the accepted beat where the symbol counter reaches NGRAM or sym_last=1, whichever comes first; the symbol counter SHALL reset to 0 on entry to INIT.
REQ-028 DRAIN SHALL last exactly 3 cycles, covering the core pipeline of memory read, m2 register and accumulate; sym_ready SHALL be 0.
REQ-029 LATCH SHALL assert core_out_period for exactly 1 cycle and then go to OUT.
REQ-030 OUT: res_valid SHALL be 1, res_data SHALL equal core_acc slice idx, res_last SHALL equal (idx==NUM_CORES-1), and idx SHALL start at 0.
REQ-031 OUT: on res_valid&&res_ready, idx SHALL increment; res_data SHALL be held stable while res_ready=0.
REQ-032 On the handshake of the last word, the FSM SHALL go to IDLE, gram_cnt SHALL increment (wrapping 0xFFFF to 0), and idx SHALL clear.
REQ-033 A symbol offered in OUT or DRAIN SHALL wait (sym_ready=0) and SHALL NOT be lost.
REQ-034 en=0 SHALL block only the IDLE->INIT transition; a gram in progress SHALL complete.
REQ-035 core_exec and core_init SHALL never be high in the same cycle.
REQ-036 Minimum gram latency SHALL be 1 IDLE cycle + 1 INIT + NGRAM EXEC + 3 DRAIN + 1 LATCH before the first res_valid.

Reset
REQ-037 While rst_n=0, the FSM SHALL be in IDLE and all outputs SHALL be 0, including gram_cnt=0, idx=0 and sym_ready=0.
REQ-038 Reset asserted mid-gram SHALL abort the gram; no out_period or result SHALL be produced for it, and the next gram SHALL start with core_init.

Verification
REQ-039 Symbols 5,6,7 back-to-back with res_ready=1 -> core_init 1 cycle, core_exec 3 cycles with src 5,6,7, 3 DRAIN cycles, out_period 1 cycle, 8 result words with res_last on the 8th, gram_cnt=1.
REQ-040 Single symbol 0 with sym_last=1 and real core instances -> all 8 res_data equal item[0]=33215360 (rotation 0).
REQ-041 Symbols 1,bubble,bubble,2,3 -> core_exec pulses only on the 3 valid beats, and DRAIN starts after symbol 3.
REQ-042 res_ready toggled 1,0,0,1,... -> no word duplicated or skipped, and res_data stable during stalls.
REQ-043 rst_n pulsed low during DRAIN -> no core_out_period, FSM in IDLE, gram_cnt unchanged at 0, and the next gram behaves as in REQ-039.
REQ-044 en=0 with sym_valid=1 for 10 cycles -> no core_init and sym_ready=0; raising en -> INIT on the next cycle.
